// File: rtl/regfile_2r1w_if.sv
// Bus bundle for regfile_2r1w: two read ports, one write port, reserve port.
// master = datapath/control side, slave = register file.
interface regfile_2r1w_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              rd_en_a;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic              busy_a;

  logic              rd_en_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              busy_b;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;

  logic              any_busy;

  modport master (
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data_a, busy_a, rd_data_b, busy_b, any_busy
  );

  modport slave (
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data_a, busy_a, rd_data_b, busy_b, any_busy
  );
endinterface

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x DATA_W register file, two registered read ports with
// write-to-read bypass, one write port, and a per-register pending bit
// (set by reserve, cleared by writeback; reserve wins on a same-cycle tie).
// Optional: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.

// One registered read port. Bypass and busy both look at the post-edge state,
// so a read issued alongside a write/reserve sees that write/reserve.
module regfile_2r1w_rd_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem_q,
  input  logic [DEPTH-1:0]              pending_d,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          busy
);
  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              busy_d, busy_q;

  // Capture bypassed data and next-state pending bit when enabled, else hold.
  always_comb begin
    rd_data_d = rd_data_q;
    busy_d    = busy_q;
    if (rd_en) begin
      if (wr_en && (wr_addr == rd_addr)) rd_data_d = wr_data;
      else                               rd_data_d = mem_q[rd_addr];
      busy_d = pending_d[rd_addr];
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
endmodule

module regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  regfile_2r1w_if.slave  bus
);
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int NUM_PORTS = 2;

  logic [DEPTH-1:0][DATA_W-1:0] mem_d, mem_q;
  logic [DEPTH-1:0]             pending_d, pending_q;
  logic                         any_busy_d, any_busy_q;
  logic                         wr_en_eff, rsv_en_eff;

  logic [NUM_PORTS-1:0]             rd_en;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data;
  logic [NUM_PORTS-1:0]             busy;

  // Qualify write/reserve; with a hardwired R0 both are dropped for address 0,
  // which also suppresses the bypass so reads of R0 always return zero.
  always_comb begin
    wr_en_eff  = bus.wr_en;
    rsv_en_eff = bus.rsv_en;
`ifdef REGFILE_ZERO_REG_EN
    if (bus.wr_addr  == '0) wr_en_eff  = 1'b0;
    if (bus.rsv_addr == '0) rsv_en_eff = 1'b0;
`endif
  end

  // Next-state storage and pending vector: write clears, reserve sets after.
  always_comb begin
    mem_d     = mem_q;
    pending_d = pending_q;
    if (wr_en_eff) begin
      mem_d[bus.wr_addr]     = bus.wr_data;
      pending_d[bus.wr_addr] = 1'b0;
    end
    if (rsv_en_eff) pending_d[bus.rsv_addr] = 1'b1;
`ifdef REGFILE_ZERO_REG_EN
    mem_d[0]     = '0;
    pending_d[0] = 1'b0;
`endif
    any_busy_d = |pending_d;
  end

  // Storage, pending bits and the summary flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '0;
      pending_q  <= '0;
      any_busy_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      pending_q  <= pending_d;
      any_busy_q <= any_busy_d;
    end
  end

  assign rd_en[0]   = bus.rd_en_a;
  assign rd_addr[0] = bus.rd_addr_a;
  assign rd_en[1]   = bus.rd_en_b;
  assign rd_addr[1] = bus.rd_addr_b;

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_rd
      regfile_2r1w_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
      ) u_rd (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en[p]),
        .rd_addr   (rd_addr[p]),
        .mem_q     (mem_q),
        .pending_d (pending_d),
        .wr_en     (wr_en_eff),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .rd_data   (rd_data[p]),
        .busy      (busy[p])
      );
    end
  endgenerate

  assign bus.rd_data_a = rd_data[0];
  assign bus.busy_a    = busy[0];
  assign bus.rd_data_b = rd_data[1];
  assign bus.busy_b    = busy[1];
  assign bus.any_busy  = any_busy_q;
endmodule
